// File: rtl/qbert_jump_ctrl.sv
// Q*bert jump command controller: turns PIO direction edges into held jump codes,
// tracks the cube position on the pyramid, and manages lives, falls and the move watchdog.
module qbert_jump_ctrl #(
  parameter int NB_ROWS    = 7,
  parameter int LIVES_INIT = 3,
  parameter int TIMEOUT    = 1 << 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nios_start_qbert,
  input  logic [3:0] dir_req,
  input  logic       done_move,
  output logic [2:0] qbert_jump,
  output logic       bad_jump,
  output logic [2:0] cube_row,
  output logic [2:0] cube_col,
  output logic [4:0] cube_idx,
  output logic       land_pulse,
  output logic       fall_pulse,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       busy,
  output logic       timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
  localparam logic signed [3:0] MAX_ROW = 4'(NB_ROWS - 1);
  localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);

  typedef enum logic [2:0] {IDLE, ISSUE, MOVE, SETTLE, OVER} state_t;

  state_t            state_reg;
  logic [3:0]        dir_reg;
  logic [3:0]        dir_prev_reg;
  logic [3:0]        dir_edge;
  logic [2:0]        jump_reg;
  logic              bad_reg;
  logic [2:0]        row_reg;
  logic [2:0]        col_reg;
  logic [2:0]        tgt_row_reg;
  logic [2:0]        tgt_col_reg;
  logic [1:0]        lives_reg;
  logic [1:0]        lives_next;
  logic              game_over_reg;
  logic              timeout_reg;
  logic              land_reg;
  logic              fall_reg;
  logic [CW-1:0]     wd_cnt_reg;

  logic [2:0]        req_code;
  logic signed [3:0] req_dr;
  logic signed [3:0] req_dc;
  logic signed [3:0] tgt_row;
  logic signed [3:0] tgt_col;
  logic              tgt_legal;
  logic [5:0]        row_base;

  assign dir_edge = dir_reg & ~dir_prev_reg;

  // Lowest set edge bit wins: DR > DL > UR > UL.
  always_comb begin
    req_code = 3'd0;
    req_dr   = 4'sd0;
    req_dc   = 4'sd0;
    if (dir_edge[0]) begin
      req_code = 3'd1; req_dr = 4'sd1;  req_dc = 4'sd1;
    end else if (dir_edge[1]) begin
      req_code = 3'd2; req_dr = 4'sd1;  req_dc = 4'sd0;
    end else if (dir_edge[2]) begin
      req_code = 3'd3; req_dr = -4'sd1; req_dc = 4'sd0;
    end else if (dir_edge[3]) begin
      req_code = 3'd4; req_dr = -4'sd1; req_dc = -4'sd1;
    end
  end

  // Signed 4-bit target so that moving up from row 0 or left from column 0 goes negative.
  assign tgt_row   = signed'({1'b0, row_reg}) + req_dr;
  assign tgt_col   = signed'({1'b0, col_reg}) + req_dc;
  assign tgt_legal = (tgt_row >= 4'sd0) && (tgt_row <= MAX_ROW) &&
                     (tgt_col >= 4'sd0) && (tgt_col <= tgt_row);

  assign lives_next = (lives_reg == 2'd0) ? 2'd0 : lives_reg - 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      dir_reg       <= 4'd0;
      dir_prev_reg  <= 4'd0;
      jump_reg      <= 3'd0;
      bad_reg       <= 1'b0;
      row_reg       <= 3'd0;
      col_reg       <= 3'd0;
      tgt_row_reg   <= 3'd0;
      tgt_col_reg   <= 3'd0;
      lives_reg     <= LIVES_RST;
      game_over_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      land_reg      <= 1'b0;
      fall_reg      <= 1'b0;
      wd_cnt_reg    <= '0;
    end else begin
      land_reg     <= 1'b0;
      fall_reg     <= 1'b0;
      dir_reg      <= dir_req;
      dir_prev_reg <= dir_reg;
      if (nios_start_qbert) begin
        // Seed edge history with the live buttons so held ones do not fire.
        dir_reg       <= dir_req;
        dir_prev_reg  <= dir_req;
        state_reg     <= IDLE;
        jump_reg      <= 3'd0;
        bad_reg       <= 1'b0;
        row_reg       <= 3'd0;
        col_reg       <= 3'd0;
        lives_reg     <= LIVES_RST;
        game_over_reg <= 1'b0;
        timeout_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (|dir_edge) begin
              jump_reg    <= req_code;
              bad_reg     <= ~tgt_legal;
              tgt_row_reg <= tgt_row[2:0];
              tgt_col_reg <= tgt_col[2:0];
              wd_cnt_reg  <= '0;
              state_reg   <= ISSUE;
            end
          end
          ISSUE, MOVE: begin
            if (wd_cnt_reg == WD_LAST) begin
              timeout_reg <= 1'b1;
              jump_reg    <= 3'd0;
              bad_reg     <= 1'b0;
              state_reg   <= IDLE;
            end else begin
              wd_cnt_reg <= wd_cnt_reg + 1'b1;
              if (state_reg == ISSUE) begin
                if (!done_move) state_reg <= MOVE;
              end else if (done_move) begin
                jump_reg  <= 3'd0;
                state_reg <= SETTLE;
                if (bad_reg) begin
                  row_reg       <= 3'd0;
                  col_reg       <= 3'd0;
                  lives_reg     <= lives_next;
                  game_over_reg <= (lives_next == 2'd0);
                  fall_reg      <= 1'b1;
                end else begin
                  row_reg  <= tgt_row_reg;
                  col_reg  <= tgt_col_reg;
                  land_reg <= 1'b1;
                end
              end
            end
          end
          SETTLE: begin
            bad_reg   <= 1'b0;
            state_reg <= game_over_reg ? OVER : IDLE;
          end
          OVER: ;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Triangular row base r*(r+1)/2; 7*8 = 56 fits in six bits.
  assign row_base = ({3'd0, row_reg} * ({3'd0, row_reg} + 6'd1)) >> 1;
  assign cube_idx = 5'(row_base + {3'd0, col_reg});

  assign qbert_jump  = jump_reg;
  assign bad_jump    = bad_reg;
  assign cube_row    = row_reg;
  assign cube_col    = col_reg;
  assign land_pulse  = land_reg;
  assign fall_pulse  = fall_reg;
  assign lives       = lives_reg;
  assign game_over   = game_over_reg;
  assign busy        = (state_reg != IDLE);
  assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// Directed bench for qbert_jump_ctrl: legal/bad jumps, game over, pyramid edges,
// request edge handling, watchdog abort, restart and reset mid-move.
module tb_qbert_jump_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       nios_start_qbert;
  logic [3:0] dir_req;
  logic       done_move;
  logic [2:0] qbert_jump;
  logic       bad_jump;
  logic [2:0] cube_row;
  logic [2:0] cube_col;
  logic [4:0] cube_idx;
  logic       land_pulse;
  logic       fall_pulse;
  logic [1:0] lives;
  logic       game_over;
  logic       busy;
  logic       timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  qbert_jump_ctrl #(.NB_ROWS(7), .LIVES_INIT(3), .TIMEOUT(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .nios_start_qbert (nios_start_qbert),
    .dir_req          (dir_req),
    .done_move        (done_move),
    .qbert_jump       (qbert_jump),
    .bad_jump         (bad_jump),
    .cube_row         (cube_row),
    .cube_col         (cube_col),
    .cube_idx         (cube_idx),
    .land_pulse       (land_pulse),
    .fall_pulse       (fall_pulse),
    .lives            (lives),
    .game_over        (game_over),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_pos(input string tag, input int r, input int c, input int idx);
    check({tag, "_row"}, 32'(cube_row), 32'(r));
    check({tag, "_col"}, 32'(cube_col), 32'(c));
    check({tag, "_idx"}, 32'(cube_idx), 32'(idx));
  endtask

  // One full jump: request edge, movement layer drops done for 3 cycles, then completes.
  task automatic jump(input logic [3:0] mask, input logic [2:0] code, input logic bad,
                      input logic hold);
    @(negedge clk) dir_req = mask;
    @(negedge clk);
    @(negedge clk);
    check("issue_code", 32'(qbert_jump), 32'(code));
    check("issue_bad", 32'(bad_jump), 32'(bad));
    if (!hold) dir_req = 4'd0;
    done_move = 1'b0;
    repeat (3) @(negedge clk);
    check("move_code", 32'(qbert_jump), 32'(code));
    check("move_bad", 32'(bad_jump), 32'(bad));
    done_move = 1'b1;
    @(negedge clk);
    check("land_pulse", 32'(land_pulse), 32'(!bad));
    check("fall_pulse", 32'(fall_pulse), 32'(bad));
    check("settle_code", 32'(qbert_jump), 32'd0);
    @(negedge clk);
    check("pulse_clear", 32'(land_pulse | fall_pulse), 32'd0);
    check("bad_clear", 32'(bad_jump), 32'd0);
    $display("jump mask=%b code=%0d bad=%0b -> pos (%0d,%0d) idx=%0d lives=%0d",
             mask, code, bad, cube_row, cube_col, cube_idx, lives);
  endtask

  task automatic restart();
    @(negedge clk) nios_start_qbert = 1'b1;
    @(negedge clk) nios_start_qbert = 1'b0;
    check("rs_lives", 32'(lives), 32'd3);
    check("rs_over", 32'(game_over), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check_pos("rs", 0, 0, 0);
    $display("restart -> lives=%0d game_over=%0b", lives, game_over);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1; nios_start_qbert = 1'b0; dir_req = 4'd0; done_move = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_code", 32'(qbert_jump), 32'd0);
    check("rst_bad", 32'(bad_jump), 32'd0);
    check_pos("rst", 0, 0, 0);
    check("rst_pulses", 32'(land_pulse | fall_pulse), 32'd0);
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    $display("reset released");
    reset = 1'b0;

    // Legal DR then UL back to the top.
    jump(4'b0001, 3'd1, 1'b0, 1'b0);
    check_pos("dr", 1, 1, 2);
    jump(4'b1000, 3'd4, 1'b0, 1'b0);
    check_pos("ul", 0, 0, 0);

    // Three bad jumps from the top end the game.
    jump(4'b0100, 3'd3, 1'b1, 1'b0);
    check("bad1_lives", 32'(lives), 32'd2);
    check_pos("bad1", 0, 0, 0);
    jump(4'b1000, 3'd4, 1'b1, 1'b0);
    check("bad2_lives", 32'(lives), 32'd1);
    jump(4'b0100, 3'd3, 1'b1, 1'b0);
    check("bad3_lives", 32'(lives), 32'd0);
    check("bad3_over", 32'(game_over), 32'd1);
    check("over_busy", 32'(busy), 32'd1);
    @(negedge clk) dir_req = 4'b0001;
    repeat (4) @(negedge clk);
    check("over_code", 32'(qbert_jump), 32'd0);
    check("over_lives", 32'(lives), 32'd0);
    $display("request in OVER -> code=%0d", qbert_jump);
    dir_req = 4'd0;
    restart();

    // Bottom row: DL walk, then an illegal DL.
    for (int i = 0; i < 6; i++) jump(4'b0010, 3'd2, 1'b0, 1'b0);
    check_pos("dl6", 6, 0, 21);
    jump(4'b0010, 3'd2, 1'b1, 1'b0);
    check("dl_off_lives", 32'(lives), 32'd2);
    check_pos("dl_off", 0, 0, 0);
    for (int i = 0; i < 6; i++) jump(4'b0001, 3'd1, 1'b0, 1'b0);
    check_pos("dr6", 6, 6, 27);
    jump(4'b0001, 3'd1, 1'b1, 1'b0);
    check("dr_off_lives", 32'(lives), 32'd1);
    restart();

    // Simultaneous bits 0 and 3, held across completion: one DR only.
    jump(4'b1001, 3'd1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("held_code", 32'(qbert_jump), 32'd0);
    check("held_busy", 32'(busy), 32'd0);
    check_pos("held", 1, 1, 2);
    $display("held request -> code=%0d busy=%0b", qbert_jump, busy);
    dir_req = 4'd0;

    // A DR edge arriving during a DL move is dropped.
    @(negedge clk) dir_req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    check("mv_code", 32'(qbert_jump), 32'd2);
    dir_req = 4'd0; done_move = 1'b0;
    @(negedge clk) dir_req = 4'b0001;
    @(negedge clk);
    @(negedge clk) done_move = 1'b1;
    @(negedge clk);
    check("mv_land", 32'(land_pulse), 32'd1);
    repeat (4) @(negedge clk);
    check("mv_drop_code", 32'(qbert_jump), 32'd0);
    check("mv_drop_busy", 32'(busy), 32'd0);
    check_pos("mv", 2, 1, 4);
    $display("edge during MOVE -> code=%0d pos (%0d,%0d)", qbert_jump, cube_row, cube_col);
    dir_req = 4'd0;

    // Watchdog: done_move never drops, abort after 16 cycles.
    @(negedge clk) dir_req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check("wd_code", 32'(qbert_jump), 32'd3);
    dir_req = 4'd0;
    repeat (15) @(negedge clk);
    check("wd_hold_code", 32'(qbert_jump), 32'd3);
    check("wd_hold_tmo", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("wd_tmo", 32'(timeout_err), 32'd1);
    check("wd_code_drop", 32'(qbert_jump), 32'd0);
    check("wd_busy", 32'(busy), 32'd0);
    check("wd_pulses", 32'(land_pulse | fall_pulse), 32'd0);
    check_pos("wd", 2, 1, 4);
    $display("watchdog -> timeout_err=%0b pos (%0d,%0d)", timeout_err, cube_row, cube_col);

    // Restart during MOVE.
    @(negedge clk) dir_req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    check("rsm_code", 32'(qbert_jump), 32'd2);
    dir_req = 4'd0; done_move = 1'b0;
    repeat (2) @(negedge clk);
    nios_start_qbert = 1'b1;
    @(negedge clk);
    nios_start_qbert = 1'b0;
    check("rsm_code0", 32'(qbert_jump), 32'd0);
    check("rsm_tmo", 32'(timeout_err), 32'd0);
    check("rsm_busy", 32'(busy), 32'd0);
    check_pos("rsm", 0, 0, 0);
    done_move = 1'b1;
    @(negedge clk);
    check("rsm_pulses", 32'(land_pulse | fall_pulse), 32'd0);
    $display("restart in MOVE -> code=%0d pos (%0d,%0d)", qbert_jump, cube_row, cube_col);

    // Reset during MOVE.
    jump(4'b0001, 3'd1, 1'b0, 1'b0);
    @(negedge clk) dir_req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    dir_req = 4'd0; done_move = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("rstm_code", 32'(qbert_jump), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_pulses", 32'(land_pulse | fall_pulse), 32'd0);
    check_pos("rstm", 0, 0, 0);
    $display("reset in MOVE -> code=%0d busy=%0b", qbert_jump, busy);
    reset = 1'b0; done_move = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
